qspi_shift_reg: RTL
===================

Name: qspi_shift_reg

Overview:
Byte-wide serializer/deserializer that feeds `io_ctrl` with `data_out` and consumes its `data_in`. It accepts one byte per `start`, shifts it out MSB-first in 1, 2 or 4-bit groups according to `mode`, and captures incoming groups into a receive byte. It is paced by the `sample_edge` strobe from `qspi_clkgen` and sits between the QSPI controller FSM and `io_ctrl`.

Parameters:
- IO_WIDTH, `IO_WIDTH_DEFAULT (4): width of the `data_out`/`data_in` buses; must be >= 4.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a byte transfer; accepted only when busy=0
- tx_byte  input  8  byte to transmit; latched on accepted start
- mode  input  2  `MODE_SINGLE` / `MODE_DUAL` / `MODE_QUAD` (qspi_definitions.vh); latched on start
- dir  input  1  `DIR_WRITE` / read; latched on start
- sample_edge  input  1  one-clk strobe from qspi_clkgen marking the SCLK sample point
- data_in  input  IO_WIDTH  bus value from io_ctrl
- data_out  output  IO_WIDTH  group presented to io_ctrl
- rx_byte  output  8  last received byte
- busy  output  1  transfer in progress
- done  output  1  one-clk pulse at transfer end

Behaviour:
- Group width G: SINGLE=1, DUAL=2, QUAD=4. Edges per byte N = 8/G (8, 4 or 2). A 4-bit edge counter counts 0..N-1.
- States:
  - IDLE: busy=0. On start with a valid mode, latch tx_byte into tx_sr, latch mode and dir, clear rx_sr and the counter, then go to SHIFT.
  - Start with an invalid mode (`MODE_ZERO` or undefined): ignored; the block stays in IDLE and no done pulse is issued.
  - SHIFT: busy=1. On each sample_edge:
    - rx_sr <= {rx_sr, captured group}.
    - tx_sr shifts left by G.
    - counter increments.
  - Leaving SHIFT: on the sample_edge where the counter equals N-1, go to IDLE next clk. In that same clk, done=1 for exactly one cycle and rx_byte <= final rx_sr value (including this edge's group).
- Captured group:
  - SINGLE: data_in[1] (MISO).
  - DUAL: data_in[1:0].
  - QUAD: data_in[3:0].
  - The higher-numbered IO line is the more significant bit.
- data_out mapping, combinational from tx_sr:
  - SINGLE: bit0 = tx_sr[7].
  - DUAL: [1:0] = tx_sr[7:6].
  - QUAD: [3:0] = tx_sr[7:4].
  - All other bits are 0.
  - When dir=read, data_out is all 0.
  - After the last edge, data_out holds its value until the next start.
- rx_byte updates only when dir=read. A write transfer leaves rx_byte unchanged but still pulses done.
- start is accepted in the done cycle (busy=0 there), giving back-to-back bytes with no idle gap.
- start while busy=1: ignored; the latched tx/mode/dir are unchanged.
- sample_edge in the same clk as an accepted start: not counted.
- sample_edge while IDLE: no effect.
- Reset (synchronous, also mid-transfer): state=IDLE, tx_sr=0, rx_sr=0, counter=0, data_out=0, rx_byte=0x00, busy=0, done=0. A reset mid-transfer produces no done pulse.
- Latency: done is asserted in the clk after the N-th counted sample_edge; busy falls in that same clk.

Test Plan:
1. QUAD write 0xA5, start then 2 sample_edges → data_out[3:0]=0xA before the 1st edge and 0x5 after it; done pulses once after the 2nd edge; rx_byte stays 0x00.
2. SINGLE read, data_in[1] sequence 1,0,1,1,0,0,1,0 over 8 sample_edges → rx_byte=0xB2 with a 1-clk done pulse; data_out=0 throughout.
3. DUAL read, data_in[1:0] = 11,00,10,01 → rx_byte=0xC9 after 4 edges; busy high for the whole transfer.
4. Start QUAD write 0x3C, assert start with 0xFF after 1 edge (ignored), then 1 more edge → second group 0xC; done after 2 edges total; a new start with 0x5A in the done cycle is accepted → data_out=0x5.
5. Reset after 3 of 8 SINGLE edges → next clk busy=0, done never pulses, data_out=0, rx_byte=0x00; a subsequent transfer completes normally.
6. start with `MODE_ZERO` → busy stays 0, no done pulse; sample_edges in IDLE leave all outputs unchanged.

Source files
------------

// File: rtl/qspi_shift_reg.sv
// Byte serializer/deserializer for the QSPI datapath: shifts tx bytes out MSB-first
// in 1/2/4-bit groups and assembles received groups, one group per sample_edge.
module qspi_shift_reg #(
  parameter int IO_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          tx_byte,
  input  logic [1:0]          mode,
  input  logic                dir,
  input  logic                sample_edge,
  input  logic [IO_WIDTH-1:0] data_in,
  output logic [IO_WIDTH-1:0] data_out,
  output logic [7:0]          rx_byte,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] MODE_ZERO   = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_DUAL   = 2'b10;
  localparam logic [1:0] MODE_QUAD   = 2'b11;
  localparam logic       DIR_WRITE   = 1'b1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t      state_reg;
  logic [7:0]  tx_sr_reg;
  logic [7:0]  rx_sr_reg;
  logic [3:0]  cnt_reg;
  logic [1:0]  mode_reg;
  logic        dir_reg;
  logic [7:0]  rx_byte_reg;
  logic        busy_reg;
  logic        done_reg;

  logic [7:0]  rx_next;
  logic [7:0]  tx_next;
  logic [3:0]  last_cnt;
  logic        start_ok;

  // Extra IO lines beyond the quad group are never sampled.
  generate
    if (IO_WIDTH > 4) begin : g_wide
      logic unused_data_in;
      assign unused_data_in = ^data_in[IO_WIDTH-1:4];
    end
  endgenerate

  assign start_ok = start && (mode != MODE_ZERO);

  always_comb begin
    rx_next  = rx_sr_reg;
    tx_next  = tx_sr_reg;
    last_cnt = 4'd7;
    case (mode_reg)
      MODE_SINGLE: begin
        rx_next  = {rx_sr_reg[6:0], data_in[1]};
        tx_next  = {tx_sr_reg[6:0], 1'b0};
        last_cnt = 4'd7;
      end
      MODE_DUAL: begin
        rx_next  = {rx_sr_reg[5:0], data_in[1:0]};
        tx_next  = {tx_sr_reg[5:0], 2'b00};
        last_cnt = 4'd3;
      end
      MODE_QUAD: begin
        rx_next  = {rx_sr_reg[3:0], data_in[3:0]};
        tx_next  = {tx_sr_reg[3:0], 4'b0000};
        last_cnt = 4'd1;
      end
      default: begin
        rx_next  = rx_sr_reg;
        tx_next  = tx_sr_reg;
        last_cnt = 4'd7;
      end
    endcase
  end

  always_comb begin
    data_out = '0;
    if (dir_reg == DIR_WRITE) begin
      case (mode_reg)
        MODE_SINGLE: data_out[0]   = tx_sr_reg[7];
        MODE_DUAL:   data_out[1:0] = tx_sr_reg[7:6];
        MODE_QUAD:   data_out[3:0] = tx_sr_reg[7:4];
        default:     data_out      = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      tx_sr_reg   <= 8'h00;
      rx_sr_reg   <= 8'h00;
      cnt_reg     <= 4'd0;
      mode_reg    <= MODE_ZERO;
      dir_reg     <= ~DIR_WRITE;
      rx_byte_reg <= 8'h00;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            tx_sr_reg <= tx_byte;
            mode_reg  <= mode;
            dir_reg   <= dir;
            rx_sr_reg <= 8'h00;
            cnt_reg   <= 4'd0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (sample_edge) begin
            rx_sr_reg <= rx_next;
            cnt_reg   <= cnt_reg + 4'd1;
            if (cnt_reg == last_cnt) begin
              // Final group is left in tx_sr so data_out holds until the next start.
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              if (dir_reg != DIR_WRITE) begin
                rx_byte_reg <= rx_next;
              end
            end else begin
              tx_sr_reg <= tx_next;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rx_byte = rx_byte_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule
